csa_seq_adder: RTL and testbench

Multi-cycle carry-select adder sequencer for the `csa` adder family. It adds two WIDTH-bit operands one BLOCK-bit slice per clock. Each cycle, both carry-in hypotheses (0 and 1) are computed for the current slice, and a per-bit 2:1 mux bank picks one using the registered carry from the previous slice. The block owns the slice counter, carry register, result register and valid/ready handshakes, so one narrow slice adder is shared across the whole word.

---
 rtl/csa_seq_adder.sv | 121 ++++++++++++
 tb/tb_csa_seq_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_adder.sv
// Sequential carry-select adder: one BLOCK-bit slice per clock, both carry
// hypotheses computed per slice and selected by the registered slice carry.
module csa_seq_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BLOCK-1:0] a_sl, b_sl;
    logic [BLOCK:0]   s0, s1, s_sel;

    // Both carry-in hypotheses for the current slice; the registered carry picks one.
    always_comb begin
        a_sl  = a_q[int'(idx_q) * BLOCK +: BLOCK];
        b_sl  = b_q[int'(idx_q) * BLOCK +: BLOCK];
        s0    = {1'b0, a_sl} + {1'b0, b_sl};
        s1    = {1'b0, a_sl} + {1'b0, b_sl} + {{BLOCK{1'b0}}, 1'b1};
        s_sel = carry_q ? s1 : s0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * BLOCK +: BLOCK] = s_sel[BLOCK-1:0];
                carry_d = s_sel[BLOCK];
                idx_d   = idx_q + CW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = s_sel[BLOCK];
                    // Sign of the freshly written top slice decides overflow.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder: directed scenarios on (32,8) plus
// concurrent random scoreboard runs on (32,8), (32,32), (32,1) and (16,4).
module tb_csa_seq_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  iv, ordy, ci;
    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    wire  [3:0]  ir, ov, co, of;
    wire  [31:0] sum0, sum1, sum2;
    wire  [15:0] sum3;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    csa_seq_adder #(.WIDTH(32), .BLOCK(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(ci[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .sum(sum0), .cout(co[0]), .ovf(of[0]));
    csa_seq_adder #(.WIDTH(32), .BLOCK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(ci[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .sum(sum1), .cout(co[1]), .ovf(of[1]));
    csa_seq_adder #(.WIDTH(32), .BLOCK(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(ci[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .sum(sum2), .cout(co[2]), .ovf(of[2]));
    csa_seq_adder #(.WIDTH(16), .BLOCK(4)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_v[3][15:0]), .b(b_v[3][15:0]), .cin(ci[3]), .out_valid(ov[3]),
        .out_ready(ordy[3]), .sum(sum3), .cout(co[3]), .ovf(of[3]));

    function automatic logic [31:0] sum_of(input int c);
        case (c)
            0:       return sum0;
            1:       return sum1;
            2:       return sum2;
            default: return {16'h0, sum3};
        endcase
    endfunction

    // Whole-word reference: {ovf, cout, sum} for a w-bit add.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input int w);
        logic [32:0] full;
        logic [31:0] s;
        logic        o, v;
        full = {1'b0, x} + {1'b0, y} + {32'h0, c};
        o    = full[w];
        s    = full[31:0];
        if (w < 32) s = s & ((32'h1 << w) - 32'h1);
        v    = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {v, o, s};
    endfunction

    task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic c,
                         output int t_acc, output bit ok);
        @(negedge clk);
        a_v[0] = x; b_v[0] = y; ci[0] = c; iv[0] = 1'b1;
        ok = 1'b0;
        t_acc = 0;
        for (int i = 0; i < 50; i++) begin
            if (ir[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t_acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
    endtask

    task automatic wait_out0(output int t_val, output bit ok);
        ok = 1'b0;
        t_val = 0;
        for (int i = 0; i < 100; i++) begin
            if (ov[0]) begin
                ok = 1'b1;
                t_val = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release0();
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ir[0] !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", ir[0]); end
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov[0]); end
        checks++; if (sum0 !== 32'h0) begin failures++; $display("FAIL reset_sum: got %h expected 0", sum0); end
        checks++; if ({co[0], of[0]} !== 2'b00) begin failures++; $display("FAIL reset_cout_ovf: got %b expected 00", {co[0], of[0]}); end
        checks++; if (ir !== 4'hF) begin failures++; $display("FAIL reset_all_ready: got %b expected 1111", ir); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({ir[0], ov[0]} !== 2'b10) begin failures++; $display("FAIL post_reset_idle: got %b expected 10", {ir[0], ov[0]}); end
    endtask

    task automatic test_basic();
        int t_acc, t_val;
        bit ok;
        logic [33:0] e;
        exp_q.push_back({1'b0, 1'b1, 32'h0000_0000});
        send0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, t_acc, ok);
        wait_out0(t_val, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL basic_timeout: got no out_valid expected out_valid");
        end else if (t_val - t_acc !== 4) begin
            failures++; $display("FAIL basic_latency: got %0d expected 4", t_val - t_acc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({of[0], co[0], sum0} !== e) begin
            failures++; $display("FAIL basic_result: got %h expected %h", {of[0], co[0], sum0}, e);
        end
        release0();
    endtask

    task automatic test_overflow();
        logic [31:0] va [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [2] = '{32'h0000_0000, 32'h8000_0000};
        logic        vc [2] = '{1'b1, 1'b0};
        logic [33:0] ve [2] = '{{1'b1, 1'b0, 32'h8000_0000}, {1'b1, 1'b1, 32'h0000_0000}};
        int t_acc, t_val;
        bit ok;
        logic [33:0] e;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(ve[k]);
            send0(va[k], vb[k], vc[k], t_acc, ok);
            wait_out0(t_val, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++; $display("FAIL ovf_timeout_%0d: got no out_valid expected out_valid", k);
            end else if ({of[0], co[0], sum0} !== e) begin
                failures++; $display("FAIL ovf_result_%0d: got %h expected %h", k, {of[0], co[0], sum0}, e);
            end
            release0();
        end
    endtask

    task automatic test_backpressure();
        int t_acc, t_val;
        bit ok;
        logic [33:0] e;
        exp_q.push_back({1'b0, 1'b0, 32'h0001_0001});
        send0(32'h0000_FFFF, 32'h0000_0001, 1'b1, t_acc, ok);
        wait_out0(t_val, ok);
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                a_v[0] = 32'hDEAD_BEEF; b_v[0] = 32'h1234_0000; ci[0] = 1'b1; iv[0] = 1'b1;
            end else begin
                iv[0] = 1'b0;
            end
            checks++;
            if ({ov[0], ir[0], of[0], co[0], sum0} !== {2'b10, e}) begin
                failures++;
                $display("FAIL hold_%0d: got %h expected %h", i, {ov[0], ir[0], of[0], co[0], sum0}, {2'b10, e});
            end
            @(negedge clk);
        end
        iv[0] = 1'b0;
        release0();
        checks++; if ({ov[0], ir[0]} !== 2'b01) begin failures++; $display("FAIL bp_exit: got %b expected 01", {ov[0], ir[0]}); end
        @(negedge clk);
        checks++;
        if ({ov[0], ir[0], of[0], co[0], sum0} !== {2'b01, e}) begin
            failures++; $display("FAIL bp_kept: got %h expected %h", {ov[0], ir[0], of[0], co[0], sum0}, {2'b01, e});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3] = '{32'h0000_0001, 32'hFFFF_0000, 32'h4000_0000};
        logic [31:0] vb [3] = '{32'h0000_0002, 32'h0001_0000, 32'h4000_0000};
        logic [33:0] ve [3] = '{{2'b00, 32'h0000_0003}, {2'b01, 32'h0000_0000}, {2'b10, 32'h8000_0000}};
        int acc [3];
        int k = 0;
        int got_n = 0;
        bit adv;
        logic [33:0] e;
        @(negedge clk);
        a_v[0] = va[0]; b_v[0] = vb[0]; ci[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
        exp_q.push_back(ve[0]);
        for (int i = 0; i < 80 && got_n < 3; i++) begin
            adv = 1'b0;
            if (iv[0] && ir[0]) begin
                acc[k] = cyc + 1; k++; adv = 1'b1;
            end
            if (ov[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra: got %h expected none", {of[0], co[0], sum0});
                end else begin
                    e = exp_q.pop_front();
                    if ({of[0], co[0], sum0} !== e) begin
                        failures++; $display("FAIL b2b_result_%0d: got %h expected %h", got_n, {of[0], co[0], sum0}, e);
                    end
                end
                got_n++;
            end
            @(negedge clk);
            if (adv) begin
                if (k < 3) begin
                    a_v[0] = va[k]; b_v[0] = vb[k]; exp_q.push_back(ve[k]);
                end else begin
                    iv[0] = 1'b0;
                end
            end
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
        checks++;
        if (got_n != 3 || k != 3) begin
            failures++; $display("FAIL b2b_count: got %0d results expected 3", got_n);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
                failures++; $display("FAIL b2b_spacing: got %0d,%0d expected 6,6", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int t_acc, t_val;
        bit ok;
        logic [33:0] e;
        exp_q.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0, 32));
        send0(32'h1234_5678, 32'h1111_1111, 1'b0, t_acc, ok);
        repeat (2) @(negedge clk);
        checks++; if (sum0 !== 32'h0000_6789) begin failures++; $display("FAIL partial_sum: got %h expected 00006789", sum0); end
        rst = 1'b1;
        #1;
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid: got %b expected 0", ov[0]); end
        checks++; if (sum0 !== 32'h0) begin failures++; $display("FAIL rst_mid_sum: got %h expected 0", sum0); end
        checks++; if (co[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_cout: got %b expected 0", co[0]); end
        checks++; if (ir[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready: got %b expected 1", ir[0]); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({2'b00, 32'd12});
        send0(32'd5, 32'd7, 1'b0, t_acc, ok);
        wait_out0(t_val, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            failures++; $display("FAIL after_rst_timeout: got no out_valid expected out_valid");
        end else if (t_val - t_acc !== 4 || {of[0], co[0], sum0} !== e) begin
            failures++; $display("FAIL after_rst_result: got lat=%0d %h expected lat=4 %h", t_val - t_acc, {of[0], co[0], sum0}, e);
        end
        release0();
    endtask

    task automatic test_random(input int c, input int n, input int w, input int nblk);
        logic [33:0] q[$];
        logic [33:0] e, got;
        logic [31:0] ra, rb;
        logic        rc;
        int sent = 0, recv = 0, cyc_n = 0, limit;
        bit pending = 1'b0;
        limit = n * (nblk + 2) * 6 + 200;
        ra = '0; rb = '0; rc = 1'b0;
        while (recv < n && cyc_n < limit) begin
            @(negedge clk);
            cyc_n++;
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                if (w < 32) begin
                    ra = ra & ((32'h1 << w) - 32'h1);
                    rb = rb & ((32'h1 << w) - 32'h1);
                end
                a_v[c] = ra; b_v[c] = rb; ci[c] = rc;
                pending = 1'b1;
            end
            iv[c] = pending;
            ordy[c] = ($urandom_range(0, 3) != 0);
            if (pending && ir[c]) begin
                q.push_back(model(ra, rb, rc, w));
                sent++;
                pending = 1'b0;
            end
            if (ov[c] && ordy[c]) begin
                got = {of[c], co[c], sum_of(c)};
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_%0d_extra: got %h expected none", c, got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        failures++; $display("FAIL rand_%0d_result_%0d: got %h expected %h", c, recv, got, e);
                    end
                end
                recv++;
            end
        end
        iv[c] = 1'b0; ordy[c] = 1'b0;
        checks++;
        if (recv < n) begin
            failures++; $display("FAIL rand_%0d_timeout: got %0d results expected %0d", c, recv, n);
        end
    endtask

    task automatic test_random_configs();
        fork
            test_random(0, 2000, 32, 4);
            test_random(1, 2000, 32, 1);
            test_random(2, 1000, 32, 32);
            test_random(3, 2000, 16, 4);
        join
    endtask

    initial begin
        iv = '0; ordy = '0; ci = '0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_configs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
